// File: rtl/nl_if_pkg.sv
// Shared types for the L1-to-next-level responder: command codes, request
// record and the service FSM state encoding.
package nl_if_pkg;

  localparam int NL_ADDR_W = 26;

  localparam logic [1:0] NL_CMD_NONE    = 2'b00;
  localparam logic [1:0] NL_CMD_READ    = 2'b01;
  localparam logic [1:0] NL_CMD_WRITE   = 2'b10;
  localparam logic [1:0] NL_CMD_ILLEGAL = 2'b11;

  typedef struct packed {
    logic [1:0]           cmd;
    logic [NL_ADDR_W-1:0] add;
  } nl_req_t;

  typedef enum logic [1:0] {
    NL_IDLE    = 2'd0,
    NL_SERVICE = 2'd1,
    NL_RESP    = 2'd2
  } nl_state_t;

endpackage

// File: rtl/nl_req_fifo.sv
// Request queue for the next-level responder; pointers carry one extra wrap
// bit so full and empty are told apart without a separate occupancy count.
module nl_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/next_level_responder.sv
// Responder end of the L1 data-cache to next-level interface: queues requests,
// services each with a fixed latency and returns a completion response.
// Traffic counters are built only when NL_STATS_EN is defined.
//
//   state   | meaning
//   IDLE    | waiting for a queued request; pops the head when one is present
//   SERVICE | fixed-latency count-down for the request in the service register
//   RESP    | resp_valid held with stable cmd/add until resp_ready
module next_level_responder
  import nl_if_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           cmd_in,
  input  logic [NL_ADDR_W-1:0] add_in,
  output logic                 in_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [1:0]           resp_cmd,
  output logic [NL_ADDR_W-1:0] resp_add,
  output logic                 busy,
  output logic [CNT_W-1:0]     reads,
  output logic [CNT_W-1:0]     writes,
  output logic [CNT_W-1:0]     errors
);

  localparam int LCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  nl_state_t                r_state;
  nl_state_t                w_state_nxt;
  logic [LCW-1:0]           r_lat_cnt;
  logic [LCW-1:0]           w_lat_cnt_nxt;
  nl_req_t                  r_svc;
  nl_req_t                  w_svc_nxt;
  nl_req_t                  w_push_req;
  nl_req_t                  w_head;
  logic [$bits(nl_req_t)-1:0] w_head_bits;
  logic                     w_is_req;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;

  assign w_is_req   = (cmd_in == NL_CMD_READ) || (cmd_in == NL_CMD_WRITE);
  assign in_ready   = !w_full;
  assign w_push     = w_is_req && !w_full;
  assign w_push_req = '{cmd: cmd_in, add: add_in};
  assign w_head     = nl_req_t'(w_head_bits);

  nl_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(nl_req_t))
  ) u_req_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_req),
    .i_pop       (w_pop),
    .o_pop_data  (w_head_bits),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    w_svc_nxt     = r_svc;
    w_pop         = 1'b0;
    case (r_state)
      NL_IDLE: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_svc_nxt     = w_head;
          w_lat_cnt_nxt = LCW'(LATENCY - 1);
          w_state_nxt   = NL_SERVICE;
        end
      end
      NL_SERVICE: begin
        if (r_lat_cnt == '0) w_state_nxt = NL_RESP;
        else                 w_lat_cnt_nxt = r_lat_cnt - LCW'(1);
      end
      NL_RESP: begin
        if (resp_ready) w_state_nxt = NL_IDLE;
      end
      default: w_state_nxt = NL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= NL_IDLE;
      r_lat_cnt <= '0;
      r_svc     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
      r_svc     <= w_svc_nxt;
    end
  end

  assign resp_valid = (r_state == NL_RESP);
  assign resp_cmd   = r_svc.cmd;
  assign resp_add   = r_svc.add;
  assign busy       = !w_empty || (r_state != NL_IDLE);

`ifdef NL_STATS_EN
  logic [CNT_W-1:0] r_reads;
  logic [CNT_W-1:0] r_writes;
  logic [CNT_W-1:0] r_errors;

  // Requests are counted at accept; illegal commands every cycle they are held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_reads  <= '0;
      r_writes <= '0;
      r_errors <= '0;
    end else begin
      if (w_push && (cmd_in == NL_CMD_READ))  r_reads  <= r_reads + CNT_W'(1);
      if (w_push && (cmd_in == NL_CMD_WRITE)) r_writes <= r_writes + CNT_W'(1);
      if (cmd_in == NL_CMD_ILLEGAL)           r_errors <= r_errors + CNT_W'(1);
    end
  end

  assign reads  = r_reads;
  assign writes = r_writes;
  assign errors = r_errors;
`else
  assign reads  = '0;
  assign writes = '0;
  assign errors = '0;
`endif

endmodule

// File: tb/tb_next_level_responder.sv
// Bench for next_level_responder: directed scenarios plus random traffic,
// checked cycle by cycle against a queue-based reference model.
module tb_next_level_responder;

  localparam int DEPTH   = 4;
  localparam int LATENCY = 3;
  localparam int CNT_W   = 32;

  logic             clk;
  logic             rst_n;
  logic [1:0]       cmd_in;
  logic [25:0]      add_in;
  logic             in_ready;
  logic             resp_valid;
  logic             resp_ready;
  logic [1:0]       resp_cmd;
  logic [25:0]      resp_add;
  logic             busy;
  logic [CNT_W-1:0] reads;
  logic [CNT_W-1:0] writes;
  logic [CNT_W-1:0] errors;

  next_level_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_in     (cmd_in),
    .add_in     (add_in),
    .in_ready   (in_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_cmd   (resp_cmd),
    .resp_add   (resp_add),
    .busy       (busy),
    .reads      (reads),
    .writes     (writes),
    .errors     (errors)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [25:0] add;
  } req_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: pending queue, one in-flight request with the edge at
  // which its response becomes visible, and plain traffic totals.
  req_t        mq[$];
  bit          m_inflight;
  req_t        m_svc;
  int unsigned m_resp_edge;
  int unsigned edge_n;
  logic [31:0] m_reads;
  logic [31:0] m_writes;
  logic [31:0] m_errors;

  function automatic logic [31:0] stat(input logic [31:0] v);
`ifdef NL_STATS_EN
    return v;
`else
    return v & 32'h0;
`endif
  endfunction

  function automatic bit m_valid();
    return m_inflight && (edge_n >= m_resp_edge);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_inflight = 0;
    m_svc      = '0;
    m_reads    = 0;
    m_writes   = 0;
    m_errors   = 0;
  endtask

  task automatic check_outputs();
    chk("in_ready", in_ready, (mq.size() < DEPTH));
    chk("resp_valid", resp_valid, m_valid());
    chk("busy", busy, (mq.size() > 0) || m_inflight);
    chk("reads", reads, stat(m_reads));
    chk("writes", writes, stat(m_writes));
    chk("errors", errors, stat(m_errors));
    if (m_valid()) begin
      chk("resp_cmd", resp_cmd, m_svc.cmd);
      chk("resp_add", resp_add, m_svc.add);
    end
  endtask

  // One clock: called at a negedge, checks, drives, steps the model, returns at next negedge.
  task automatic cycle(input logic [1:0] c, input logic [25:0] a, input logic r);
    bit can_acc;
    bit hs;
    bit was_idle;
    check_outputs();
    cmd_in     = c;
    add_in     = a;
    resp_ready = r;
    can_acc  = (mq.size() < DEPTH);
    hs       = m_valid() && r;
    was_idle = !m_inflight;
    @(posedge clk);
    edge_n++;
    if (hs) m_inflight = 0;
    if (was_idle && mq.size() > 0) begin
      m_svc       = mq.pop_front();
      m_inflight  = 1;
      m_resp_edge = edge_n + LATENCY;
    end
    if ((c == 2'b01 || c == 2'b10) && can_acc) begin
      mq.push_back('{cmd: c, add: a});
      if (c == 2'b01) m_reads++;
      else            m_writes++;
    end
    if (c == 2'b11) m_errors++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    cmd_in     = 2'b00;
    add_in     = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    edge_n += 2;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_cmd", resp_cmd, 2'b00);
    chk("rst_resp_add", resp_add, 26'h0);
    chk("rst_reads", reads, 32'h0);
    chk("rst_writes", writes, 32'h0);
    chk("rst_errors", errors, 32'h0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_inflight || mq.size() > 0) && n < budget) begin
      cycle(2'b00, '0, 1'b1);
      n++;
    end
    chk("drain_done", (m_inflight || mq.size() > 0), 1'b0);
  endtask

  initial begin
    int lat;
    logic [31:0] err0;
    rst_n      = 1'b0;
    cmd_in     = 2'b00;
    add_in     = '0;
    resp_ready = 1'b0;
    edge_n     = 0;
    model_clear();
    @(negedge clk);
    do_reset();

    // single read and its latency
    cycle(2'b01, 26'h0ABCDEF, 1'b1);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      cycle(2'b00, '0, 1'b1);
      lat++;
    end
    chk("single_latency", lat, LATENCY + 1);
    chk("single_cmd", resp_cmd, 2'b01);
    chk("single_add", resp_add, 26'h0ABCDEF);
    chk("single_reads", reads, stat(32'd1));
    drain(20);

    // fill under back-pressure, one extra write while full, then in-order drain
    for (int i = 0; i < 5; i++) cycle(2'b10, 26'h100 + 26'(i), 1'b0);
    chk("fill_in_ready", in_ready, 1'b0);
    chk("fill_writes", writes, stat(32'd5));
    cycle(2'b10, 26'h3FF_FFFF, 1'b0);
    chk("full_write_dropped", writes, stat(32'd5));
    repeat (6) cycle(2'b00, '0, 1'b0);
    chk("stall_valid_held", resp_valid, 1'b1);
    chk("stall_first_add", resp_add, 26'h100);
    drain(80);

    // illegal commands
    err0 = m_errors;
    repeat (3) cycle(2'b11, 26'h55, 1'b1);
    cycle(2'b00, '0, 1'b1);
    chk("illegal_errors", errors, stat(err0 + 32'd3));
    chk("illegal_busy", busy, 1'b0);
    chk("illegal_no_resp", resp_valid, 1'b0);

    // reset during service
    cycle(2'b01, 26'h200, 1'b1);
    cycle(2'b01, 26'h201, 1'b1);
    cycle(2'b00, '0, 1'b1);
    chk("mid_busy_before", busy, 1'b1);
    @(posedge clk); edge_n++;
    @(negedge clk);
    do_reset();
    repeat (10) cycle(2'b00, '0, 1'b1);

    // ten spaced reads
    for (int i = 0; i < 10; i++) begin
      cycle(2'b01, 26'h3000 + 26'(i), 1'b1);
      drain(20);
    end
    chk("ten_reads", reads, stat(32'd10));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [1:0] c;
      r = $urandom_range(0, 9);
      c = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      cycle(c, 26'($urandom), ($urandom_range(0, 3) != 0));
    end
    drain(100);

    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule
